// File: rtl/scene_packet_parser_pkg.sv
// Shared types for the scene packet parser: circle record, parser states,
// and the default packet start marker.
package Types;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [11:0] r;
    } Circle;

    typedef enum logic [3:0] {
        ST_IDLE, ST_ID, ST_XH, ST_XL, ST_YH, ST_YL, ST_RH, ST_RL, ST_CHK
    } pkt_state_e;

    localparam Circle CIRCLE_RESET0 = '{x: 12'd0, y: 12'd0, r: 12'd20};
endpackage

// File: rtl/scene_packet_parser_timeout.sv
// Inter-byte watchdog: counts idle cycles while a packet is open and flags
// expiry once TIMEOUT_CYCLES cycles have passed without a byte.
module packet_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic count,
    input  logic clear,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !count)
            cnt_d = '0;
        else if (cnt_q != LIMIT)
            cnt_d = cnt_q + 1'b1;
    end

    // A byte in the expiry cycle takes priority over the timeout.
    assign expire = count && !clear && (cnt_q == LIMIT);

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/scene_packet_parser.sv
// Parses 9-byte circle packets from the SPI receiver into a shadow scene and
// publishes the whole scene to the raytracer only on frame_sync.
module scene_packet_parser
    import Types::*;
#(
    parameter int         N_CIRCLES      = 4,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
    input  logic                    CLK100MHZ,
    input  logic                    ck_rst,
    input  logic                    recv_dv,
    input  logic [7:0]              recv_byte,
    input  logic                    frame_sync,
    output Circle [N_CIRCLES-1:0]   circles,
    output logic                    pkt_ok,
    output logic                    pkt_err,
    output logic [7:0]              err_count
);
    pkt_state_e state_q, state_d;
    logic [7:0] xor_q, xor_d;
    logic [3:0] id_q, id_d;
    Circle      stage_q, stage_d;
    Circle [N_CIRCLES-1:0] shadow_q, shadow_d, circles_q, circles_d;
    logic       pkt_ok_q, pkt_ok_d, pkt_err_q, pkt_err_d;
    logic [7:0] err_count_q, err_count_d;
    logic       tmo_expire, fail, commit;

    packet_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk    (CLK100MHZ),
        .rst    (ck_rst),
        .count  (state_q != ST_IDLE),
        .clear  (recv_dv),
        .expire (tmo_expire)
    );

    always_comb begin
        state_d     = state_q;
        xor_d       = xor_q;
        id_d        = id_q;
        stage_d     = stage_q;
        shadow_d    = shadow_q;
        err_count_d = err_count_q;
        pkt_ok_d    = 1'b0;
        pkt_err_d   = 1'b0;
        fail        = 1'b0;
        commit      = 1'b0;
        // Publish samples the shadow before any same-cycle commit lands.
        circles_d   = frame_sync ? shadow_q : circles_q;

        if (recv_dv) begin
            unique case (state_q)
                ST_IDLE: if (recv_byte == SYNC_BYTE) begin
                    state_d = ST_ID;
                    xor_d   = 8'h00;
                end
                ST_ID: begin
                    xor_d = xor_q ^ recv_byte;
                    id_d  = recv_byte[3:0];
                    if (int'(recv_byte) >= N_CIRCLES) fail = 1'b1;
                    else                              state_d = ST_XH;
                end
                ST_XH: begin
                    xor_d = xor_q ^ recv_byte;
                    stage_d.x[11:8] = recv_byte[3:0];
                    if (recv_byte[7:4] != 4'h0) fail = 1'b1;
                    else                        state_d = ST_XL;
                end
                ST_XL: begin
                    xor_d = xor_q ^ recv_byte;
                    stage_d.x[7:0] = recv_byte;
                    state_d = ST_YH;
                end
                ST_YH: begin
                    xor_d = xor_q ^ recv_byte;
                    stage_d.y[11:8] = recv_byte[3:0];
                    if (recv_byte[7:4] != 4'h0) fail = 1'b1;
                    else                        state_d = ST_YL;
                end
                ST_YL: begin
                    xor_d = xor_q ^ recv_byte;
                    stage_d.y[7:0] = recv_byte;
                    state_d = ST_RH;
                end
                ST_RH: begin
                    xor_d = xor_q ^ recv_byte;
                    stage_d.r[11:8] = recv_byte[3:0];
                    if (recv_byte[7:4] != 4'h0) fail = 1'b1;
                    else                        state_d = ST_RL;
                end
                ST_RL: begin
                    xor_d = xor_q ^ recv_byte;
                    stage_d.r[7:0] = recv_byte;
                    state_d = ST_CHK;
                end
                ST_CHK: begin
                    if (recv_byte == xor_q) commit = 1'b1;
                    else                    fail   = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (tmo_expire) begin
            fail = 1'b1;
        end

        if (fail) begin
            state_d   = ST_IDLE;
            pkt_err_d = 1'b1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end
        if (commit) begin
            state_d  = ST_IDLE;
            pkt_ok_d = 1'b1;
            for (int i = 0; i < N_CIRCLES; i++)
                if (id_q == 4'(i)) shadow_d[i] = stage_q;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (ck_rst) begin
            state_q     <= ST_IDLE;
            xor_q       <= 8'h00;
            id_q        <= 4'h0;
            stage_q     <= '0;
            pkt_ok_q    <= 1'b0;
            pkt_err_q   <= 1'b0;
            err_count_q <= 8'h00;
            for (int i = 0; i < N_CIRCLES; i++) begin
                shadow_q[i]  <= (i == 0) ? CIRCLE_RESET0 : '0;
                circles_q[i] <= (i == 0) ? CIRCLE_RESET0 : '0;
            end
        end else begin
            state_q     <= state_d;
            xor_q       <= xor_d;
            id_q        <= id_d;
            stage_q     <= stage_d;
            pkt_ok_q    <= pkt_ok_d;
            pkt_err_q   <= pkt_err_d;
            err_count_q <= err_count_d;
            shadow_q    <= shadow_d;
            circles_q   <= circles_d;
        end
    end

    assign circles   = circles_q;
    assign pkt_ok    = pkt_ok_q;
    assign pkt_err   = pkt_err_q;
    assign err_count = err_count_q;
endmodule

// File: tb/tb_scene_packet_parser.sv
// Bench for scene_packet_parser: directed scenarios plus randomized packet
// streams checked against a byte-array packet model.
module tb_scene_packet_parser;
    import Types::*;
    localparam int N = 4;
    localparam int T = 40;

    logic clk = 1'b0;
    logic rst = 1'b0, dv = 1'b0, fs = 1'b0;
    logic [7:0] b = 8'h00;
    Circle [N-1:0] circles;
    logic pkt_ok, pkt_err;
    logic [7:0] err_count;
    logic [N-1:0][35:0] circ_w;
    assign circ_w = circles;

    always #5 clk = ~clk;

    scene_packet_parser #(.N_CIRCLES(N), .TIMEOUT_CYCLES(T), .SYNC_BYTE(8'hA5)) dut (
        .CLK100MHZ (clk),
        .ck_rst    (rst),
        .recv_dv   (dv),
        .recv_byte (b),
        .frame_sync(fs),
        .circles   (circles),
        .pkt_ok    (pkt_ok),
        .pkt_err   (pkt_err),
        .err_count (err_count)
    );

    int n_checks = 0, n_fail = 0;
    int m_pos, m_idle, m_cnt;
    logic [7:0] m_buf [9];
    logic [N-1:0][35:0] m_shadow, m_circ;
    logic m_ok, m_err;
    logic [7:0] pkt [9];

    function automatic logic [35:0] c36(input int x, input int y, input int r);
        return {12'(x), 12'(y), 12'(r)};
    endfunction

    task automatic model_reset();
        m_pos = 0; m_idle = 0; m_cnt = 0; m_ok = 0; m_err = 0;
        m_shadow = '0;
        m_shadow[0] = c36(0, 0, 20);
        m_circ = m_shadow;
    endtask

    task automatic model_fail();
        m_pos = 0; m_err = 1;
        if (m_cnt < 255) m_cnt++;
    endtask

    // Packet-level model: collect bytes by position, judge each per the format rules.
    task automatic model_step(input logic vdv, input logic [7:0] vb, input logic vfs);
        logic [N-1:0][35:0] pre;
        logic [7:0] x;
        pre = m_shadow;
        m_ok = 0; m_err = 0;
        if (vdv) begin
            m_idle = 0;
            if (m_pos == 0) begin
                if (vb == 8'hA5) m_pos = 1;
            end else begin
                m_buf[m_pos] = vb;
                if (m_pos == 1 && int'(vb) >= N) model_fail();
                else if ((m_pos == 2 || m_pos == 4 || m_pos == 6) && vb[7:4] != 0) model_fail();
                else if (m_pos == 8) begin
                    x = 8'h00;
                    for (int k = 1; k <= 7; k++) x = x ^ m_buf[k];
                    if (x != vb) model_fail();
                    else begin
                        m_shadow[m_buf[1][1:0]] = {m_buf[2][3:0], m_buf[3], m_buf[4][3:0],
                                                   m_buf[5], m_buf[6][3:0], m_buf[7]};
                        m_ok = 1; m_pos = 0;
                    end
                end else m_pos++;
            end
        end else if (m_pos != 0) begin
            m_idle++;
            if (m_idle >= T) begin model_fail(); m_idle = 0; end
        end
        if (vfs) m_circ = pre;
    endtask

    task automatic drive(input logic vdv, input logic [7:0] vb, input logic vfs);
        dv = vdv; b = vb; fs = vfs;
        model_step(vdv, vb, vfs);
        @(posedge clk); #1;
        dv = 1'b0; fs = 1'b0;
    endtask

    task automatic do_reset(input logic vdv);
        rst = 1'b1; dv = vdv; b = 8'hA5; fs = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; dv = 1'b0; fs = 1'b0;
        model_reset();
    endtask

    task automatic build_pkt(input int id, input int x, input int y, input int r);
        pkt[0] = 8'hA5; pkt[1] = 8'(id);
        pkt[2] = {4'h0, 4'(x >> 8)}; pkt[3] = 8'(x);
        pkt[4] = {4'h0, 4'(y >> 8)}; pkt[5] = 8'(y);
        pkt[6] = {4'h0, 4'(r >> 8)}; pkt[7] = 8'(r);
        pkt[8] = 8'h00;
        for (int k = 1; k <= 7; k++) pkt[8] = pkt[8] ^ pkt[k];
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        n_checks++; if ({pkt_ok, pkt_err} !== 2'b00) begin n_fail++;
            $display("FAIL reset_pulses got=%b exp=00", {pkt_ok, pkt_err}); end
        n_checks++; if (err_count !== 8'd0) begin n_fail++;
            $display("FAIL reset_errcnt got=%0d exp=0", err_count); end
        n_checks++; if (circ_w[0] !== c36(0, 0, 20)) begin n_fail++;
            $display("FAIL reset_circ0 got=%h exp=%h", circ_w[0], c36(0, 0, 20)); end
        drive(1'b0, 8'h00, 1'b1);
        n_checks++; if (circ_w[0] !== c36(0, 0, 20) || circ_w[3:1] !== '0) begin n_fail++;
            $display("FAIL reset_publish got=%h", circ_w); end
    endtask

    task automatic test_valid_packet();
        logic [7:0] seq [9] = '{8'hA5, 8'h01, 8'h00, 8'h50, 8'h00, 8'h3C, 8'h00, 8'h0A, 8'h67};
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, seq[i], 1'b0);
            if (i < 8) begin
                n_checks++; if (pkt_ok !== 1'b0) begin n_fail++;
                    $display("FAIL valid_early_ok byte=%0d got=%b exp=0", i, pkt_ok); end
            end
        end
        n_checks++; if ({pkt_ok, pkt_err} !== 2'b10) begin n_fail++;
            $display("FAIL valid_ok got=%b exp=10", {pkt_ok, pkt_err}); end
        n_checks++; if (circ_w[1] !== 36'd0) begin n_fail++;
            $display("FAIL valid_tearfree got=%h exp=0", circ_w[1]); end
        drive(1'b0, 8'h00, 1'b0);
        n_checks++; if (pkt_ok !== 1'b0) begin n_fail++;
            $display("FAIL valid_ok_width got=%b exp=0", pkt_ok); end
        drive(1'b0, 8'h00, 1'b1);
        n_checks++; if (circ_w[1] !== c36(80, 60, 10)) begin n_fail++;
            $display("FAIL valid_publish got=%h exp=%h", circ_w[1], c36(80, 60, 10)); end
    endtask

    task automatic test_bad_chk();
        logic [7:0] seq [9] = '{8'hA5, 8'h01, 8'h00, 8'h50, 8'h00, 8'h3C, 8'h00, 8'h0A, 8'h66};
        for (int i = 0; i < 9; i++) drive(1'b1, seq[i], 1'b0);
        n_checks++; if ({pkt_ok, pkt_err} !== 2'b01) begin n_fail++;
            $display("FAIL badchk_err got=%b exp=01", {pkt_ok, pkt_err}); end
        n_checks++; if (err_count !== 8'd1) begin n_fail++;
            $display("FAIL badchk_cnt got=%0d exp=1", err_count); end
        drive(1'b0, 8'h00, 1'b1);
        n_checks++; if (circ_w !== m_circ || circ_w[1] !== c36(80, 60, 10)) begin n_fail++;
            $display("FAIL badchk_shadow got=%h exp=%h", circ_w, m_circ); end
    endtask

    task automatic test_bad_id();
        drive(1'b1, 8'hA5, 1'b0);
        drive(1'b1, 8'h07, 1'b0);
        n_checks++; if ({pkt_ok, pkt_err} !== 2'b01 || err_count !== 8'd2) begin n_fail++;
            $display("FAIL badid_err got=%b cnt=%0d exp=01 cnt=2", {pkt_ok, pkt_err}, err_count); end
        build_pkt(2, 100, 200, 300);
        for (int i = 0; i < 9; i++) drive(1'b1, pkt[i], 1'b0);
        n_checks++; if (pkt_ok !== 1'b1) begin n_fail++;
            $display("FAIL badid_recover got=%b exp=1", pkt_ok); end
        drive(1'b0, 8'h00, 1'b1);
        n_checks++; if (circ_w[2] !== c36(100, 200, 300)) begin n_fail++;
            $display("FAIL badid_publish got=%h exp=%h", circ_w[2], c36(100, 200, 300)); end
    endtask

    task automatic test_timeout();
        int early = 0;
        drive(1'b1, 8'hA5, 1'b0);
        drive(1'b1, 8'h02, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < T - 1; i++) begin
            drive(1'b0, 8'h00, 1'b0);
            if (pkt_err !== 1'b0) early++;
        end
        n_checks++; if (early != 0) begin n_fail++;
            $display("FAIL timeout_early got=%0d exp=0 err pulses", early); end
        drive(1'b0, 8'h00, 1'b0);
        n_checks++; if (pkt_err !== 1'b1 || err_count !== 8'd3) begin n_fail++;
            $display("FAIL timeout_err got=%b cnt=%0d exp=1 cnt=3", pkt_err, err_count); end
        build_pkt(3, 1, 2, 3);
        for (int i = 0; i < 9; i++) drive(1'b1, pkt[i], 1'b0);
        n_checks++; if (pkt_ok !== 1'b1) begin n_fail++;
            $display("FAIL timeout_restart got=%b exp=1", pkt_ok); end
    endtask

    task automatic test_commit_frame_sync();
        build_pkt(1, 5, 6, 7);
        for (int i = 0; i < 9; i++) drive(1'b1, pkt[i], i == 8);
        n_checks++; if (pkt_ok !== 1'b1 || circ_w[1] !== c36(80, 60, 10)) begin n_fail++;
            $display("FAIL commitfs_old got=%h ok=%b exp=%h ok=1", circ_w[1], pkt_ok, c36(80, 60, 10)); end
        drive(1'b0, 8'h00, 1'b1);
        n_checks++; if (circ_w[1] !== c36(5, 6, 7)) begin n_fail++;
            $display("FAIL commitfs_new got=%h exp=%h", circ_w[1], c36(5, 6, 7)); end
    endtask

    task automatic test_reset_midpacket();
        drive(1'b1, 8'hA5, 1'b0);
        drive(1'b1, 8'h01, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        do_reset(1'b1);
        drive(1'b0, 8'h00, 1'b0);
        n_checks++; if (pkt_err !== 1'b0 || err_count !== 8'd0) begin n_fail++;
            $display("FAIL resetmid got=%b cnt=%0d exp=0 cnt=0", pkt_err, err_count); end
        n_checks++; if (circ_w !== m_circ) begin n_fail++;
            $display("FAIL resetmid_circ got=%h exp=%h", circ_w, m_circ); end
    endtask

    task automatic test_random();
        bit qdv [$];
        logic [7:0] qb [$];
        int bad = 0, both = 0;
        for (int p = 0; p < 60; p++) begin
            int kind = $urandom_range(0, 9);
            int id = (kind == 0) ? $urandom_range(4, 255) : $urandom_range(0, N - 1);
            int len = 9;
            build_pkt(0, $urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095));
            pkt[1] = 8'(id);
            pkt[8] = 8'h00;
            for (int k = 1; k <= 7; k++) pkt[8] = pkt[8] ^ pkt[k];
            if (kind == 1) pkt[8] = pkt[8] ^ (8'h01 << $urandom_range(0, 7));
            if (kind == 2) pkt[2 * $urandom_range(1, 3)][7:4] = 4'($urandom_range(1, 15));
            if (kind == 3) len = $urandom_range(2, 8);
            for (int k = 0; k < len; k++) begin
                qdv.push_back(1'b1); qb.push_back(pkt[k]);
                repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0) begin
                    qdv.push_back(1'b0); qb.push_back(8'h00);
                end
            end
            if (kind == 3) repeat (T + 3) begin qdv.push_back(1'b0); qb.push_back(8'h00); end
            if ($urandom_range(0, 3) == 0) begin
                logic [7:0] nz = 8'($urandom_range(0, 255));
                if (nz == 8'hA5) nz = 8'h00;
                qdv.push_back(1'b1); qb.push_back(nz);
            end
        end
        while (qdv.size() > 0) begin
            drive(qdv.pop_front(), qb.pop_front(), $urandom_range(0, 6) == 0);
            if (pkt_ok !== m_ok || pkt_err !== m_err || err_count !== 8'(m_cnt) || circ_w !== m_circ)
                bad++;
            if (pkt_ok && pkt_err) both++;
        end
        n_checks++; if (bad != 0) begin n_fail++;
            $display("FAIL random_stream got=%0d exp=0 mismatching cycles", bad); end
        n_checks++; if (both != 0) begin n_fail++;
            $display("FAIL random_exclusive got=%0d exp=0 overlap cycles", both); end
        drive(1'b0, 8'h00, 1'b1);
        n_checks++; if (circ_w !== m_circ) begin n_fail++;
            $display("FAIL random_final got=%h exp=%h", circ_w, m_circ); end
    endtask

    task automatic test_err_saturation();
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 8'hA5, 1'b0);
            drive(1'b1, 8'h07, 1'b0);
        end
        n_checks++; if (err_count !== 8'd255 || err_count !== 8'(m_cnt)) begin n_fail++;
            $display("FAIL err_saturate got=%0d exp=255", err_count); end
        n_checks++; if (pkt_err !== 1'b1) begin n_fail++;
            $display("FAIL err_saturate_pulse got=%b exp=1", pkt_err); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_valid_packet();
        test_bad_chk();
        test_bad_id();
        test_timeout();
        test_commit_frame_sync();
        test_reset_midpacket();
        test_random();
        test_err_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
